// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue scheduler between decode and the DO/M/MEM units.
// Tracks pending writers per register and CPSR, sequences the multiplier, bounds loads.
module issue_scoreboard #(
   parameter int M_LATENCY = 4,
   parameter int LD_MAX    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uop_valid_i,
   output logic        uop_ready_o,
   input  logic [1:0]  uop_class_i,
   input  logic [3:0]  uop_src_en_i,
   input  logic [3:0]  uop_src1_i,
   input  logic [3:0]  uop_src2_i,
   input  logic [3:0]  uop_src3_i,
   input  logic [3:0]  uop_src4_i,
   input  logic        uop_dest_en_i,
   input  logic [3:0]  uop_dest_i,
   input  logic        uop_cpsr_rd_i,
   input  logic        uop_cpsr_wr_i,
   input  logic        wb_valid_i,
   input  logic [3:0]  wb_dest_i,
   output logic        issue_do_o,
   output logic        issue_m_o,
   output logic        issue_mem_o,
   output logic [3:0]  fwd_mask_o,
   output logic        m_busy_o,
   output logic [1:0]  ld_count_o,
   output logic [15:0] pending_o,
   output logic        err_o
);

   localparam int CW = (M_LATENCY > 1) ? $clog2(M_LATENCY) : 1;
   localparam logic [CW-1:0] M_LOAD = CW'(M_LATENCY - 1);
   localparam logic [1:0] LD_LIM = 2'(LD_MAX);
   localparam logic [3:0] PC = 4'd15;

   localparam logic [1:0] CL_DO  = 2'd0;
   localparam logic [1:0] CL_MUL = 2'd1;
   localparam logic [1:0] CL_LD  = 2'd2;
   localparam logic [1:0] CL_ST  = 2'd3;

   typedef enum logic [1:0] {
      OWN_DO = 2'd0,
      OWN_M  = 2'd1,
      OWN_LD = 2'd2
   } own_t;

   typedef enum logic {
      M_IDLE,
      M_BUSY
   } m_state_t;

   logic [15:0] pend_q, pend_d;
   own_t        own_q [16];
   own_t        own_d [16];
   logic        cpsr_q, cpsr_d;
   m_state_t    m_q, m_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]  mdst_q, mdst_d;
   logic        mdst_en_q, mdst_en_d;
   logic [1:0]  ld_q, ld_d;
   logic        err_q, err_d;

   logic [3:0]  src [4];
   logic [3:0]  fwd;
   logic        src_stall;
   logic        waw;
   logic        hazard;
   logic        m_free;
   logic        unit_ok;
   logic        fire;
   logic        wb_ok;
   logic        ld_inc;
   logic        set_en;
   own_t        set_own;
   logic        m_clr;

   assign src[0] = uop_src1_i;
   assign src[1] = uop_src2_i;
   assign src[2] = uop_src3_i;
   assign src[3] = uop_src4_i;

   // DO-owned sources are one cycle old and ride the result forward path
   always_comb begin
      src_stall = 1'b0;
      fwd       = '0;
      for (int i = 0; i < 4; i++) begin
         if (uop_src_en_i[i] && src[i] != PC && pend_q[src[i]]) begin
            if (own_q[src[i]] == OWN_DO) fwd[i] = 1'b1;
            else src_stall = 1'b1;
         end
      end
   end

   assign waw = uop_dest_en_i && uop_dest_i != PC &&
                pend_q[uop_dest_i] && own_q[uop_dest_i] != OWN_DO;
   assign hazard = src_stall || waw || (uop_cpsr_rd_i && cpsr_q);
   assign m_free = (m_q == M_IDLE) || (cnt_q == '0);

   always_comb begin
      unit_ok = 1'b1;
      unique case (uop_class_i)
         CL_MUL:  unit_ok = m_free;
         CL_LD:   unit_ok = (ld_q < LD_LIM) ||
                            (ld_q == LD_LIM && wb_valid_i);
         default: unit_ok = 1'b1;
      endcase
   end

   assign uop_ready_o = !rst && !hazard && unit_ok;
   assign fire        = uop_valid_i && uop_ready_o;
   assign issue_do_o  = fire && uop_class_i == CL_DO;
   assign issue_m_o   = fire && uop_class_i == CL_MUL;
   assign issue_mem_o = fire && uop_class_i[1];
   assign fwd_mask_o  = fire ? fwd : 4'd0;

   assign wb_ok  = wb_valid_i && ld_q != 2'd0;
   assign ld_inc = issue_mem_o && uop_class_i == CL_LD;
   assign set_en = fire && uop_dest_en_i && uop_dest_i != PC &&
                   uop_class_i != CL_ST;
   assign set_own = issue_m_o ? OWN_M : (issue_mem_o ? OWN_LD : OWN_DO);

   always_comb begin
      m_d       = m_q;
      cnt_d     = cnt_q;
      mdst_d    = mdst_q;
      mdst_en_d = mdst_en_q;
      m_clr     = 1'b0;
      unique case (m_q)
         M_IDLE: begin
            if (issue_m_o) begin
               m_d   = M_BUSY;
               cnt_d = M_LOAD;
            end
         end
         M_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               m_clr = 1'b1;
               if (issue_m_o) cnt_d = M_LOAD;
               else m_d = M_IDLE;
            end
         end
      endcase
      if (issue_m_o) begin
         mdst_d    = uop_dest_i;
         mdst_en_d = uop_dest_en_i && uop_dest_i != PC;
      end
   end

   // clears first, then the new issue's set so it wins on a collision
   always_comb begin
      pend_d = pend_q;
      own_d  = own_q;
      for (int r = 0; r < 16; r++) begin
         if (pend_q[r] && own_q[r] == OWN_DO) pend_d[r] = 1'b0;
      end
      if (m_clr && mdst_en_q && own_q[mdst_q] == OWN_M)
         pend_d[mdst_q] = 1'b0;
      if (wb_ok && own_q[wb_dest_i] == OWN_LD)
         pend_d[wb_dest_i] = 1'b0;
      if (set_en) begin
         pend_d[uop_dest_i] = 1'b1;
         own_d[uop_dest_i]  = set_own;
      end
   end

   always_comb begin
      ld_d = ld_q;
      unique case ({ld_inc, wb_ok})
         2'b10:   ld_d = ld_q + 2'd1;
         2'b01:   ld_d = ld_q - 2'd1;
         default: ld_d = ld_q;
      endcase
   end

   assign cpsr_d = issue_do_o && uop_cpsr_wr_i;
   assign err_d  = err_q || (wb_valid_i && ld_q == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q    <= '0;
         cpsr_q    <= 1'b0;
         m_q       <= M_IDLE;
         cnt_q     <= '0;
         mdst_q    <= '0;
         mdst_en_q <= 1'b0;
         ld_q      <= '0;
         err_q     <= 1'b0;
         for (int r = 0; r < 16; r++) own_q[r] <= OWN_DO;
      end else begin
         pend_q    <= pend_d;
         cpsr_q    <= cpsr_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         mdst_q    <= mdst_d;
         mdst_en_q <= mdst_en_d;
         ld_q      <= ld_d;
         err_q     <= err_d;
         for (int r = 0; r < 16; r++) own_q[r] <= own_d[r];
      end
   end

   assign m_busy_o   = (m_q == M_BUSY);
   assign ld_count_o = ld_q;
   assign pending_o  = pend_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized and directed bench for issue_scoreboard.
// Reference model tracks register writers as plain integer tags.
module tb_issue_scoreboard;

   localparam int M_LATENCY = 4;
   localparam int LD_MAX    = 2;

   localparam int K_NONE = 0;
   localparam int K_DO   = 1;
   localparam int K_M    = 2;
   localparam int K_LD   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        uop_valid_i;
   logic        uop_ready_o;
   logic [1:0]  uop_class_i;
   logic [3:0]  uop_src_en_i;
   logic [3:0]  uop_src1_i, uop_src2_i, uop_src3_i, uop_src4_i;
   logic        uop_dest_en_i;
   logic [3:0]  uop_dest_i;
   logic        uop_cpsr_rd_i, uop_cpsr_wr_i;
   logic        wb_valid_i;
   logic [3:0]  wb_dest_i;
   logic        issue_do_o, issue_m_o, issue_mem_o;
   logic [3:0]  fwd_mask_o;
   logic        m_busy_o;
   logic [1:0]  ld_count_o;
   logic [15:0] pending_o;
   logic        err_o;

   issue_scoreboard #(
      .M_LATENCY(M_LATENCY),
      .LD_MAX(LD_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .uop_valid_i(uop_valid_i),
      .uop_ready_o(uop_ready_o),
      .uop_class_i(uop_class_i),
      .uop_src_en_i(uop_src_en_i),
      .uop_src1_i(uop_src1_i),
      .uop_src2_i(uop_src2_i),
      .uop_src3_i(uop_src3_i),
      .uop_src4_i(uop_src4_i),
      .uop_dest_en_i(uop_dest_en_i),
      .uop_dest_i(uop_dest_i),
      .uop_cpsr_rd_i(uop_cpsr_rd_i),
      .uop_cpsr_wr_i(uop_cpsr_wr_i),
      .wb_valid_i(wb_valid_i),
      .wb_dest_i(wb_dest_i),
      .issue_do_o(issue_do_o),
      .issue_m_o(issue_m_o),
      .issue_mem_o(issue_mem_o),
      .fwd_mask_o(fwd_mask_o),
      .m_busy_o(m_busy_o),
      .ld_count_o(ld_count_o),
      .pending_o(pending_o),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   int kind [16];
   bit cpsr_p;
   int m_left;
   int m_reg;
   int ld_n;
   bit err_m;
   int ldq [$];
   bit last_fire;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 16; r++) kind[r] = K_NONE;
      cpsr_p = 1'b0;
      m_left = -1;
      m_reg  = -1;
      ld_n   = 0;
      err_m  = 1'b0;
      ldq.delete();
   endtask

   task automatic set_uop(input bit v, input int c, input logic [3:0] se,
                          input logic [3:0] s1, input bit de,
                          input logic [3:0] d, input bit cr, input bit cw);
      uop_valid_i   = v;
      uop_class_i   = 2'(c);
      uop_src_en_i  = se;
      uop_src1_i    = s1;
      uop_src2_i    = 4'd0;
      uop_src3_i    = 4'd0;
      uop_src4_i    = 4'd0;
      uop_dest_en_i = de;
      uop_dest_i    = d;
      uop_cpsr_rd_i = cr;
      uop_cpsr_wr_i = cw;
   endtask

   task automatic set_wb(input bit v, input logic [3:0] d);
      wb_valid_i = v;
      wb_dest_i  = d;
   endtask

   task automatic idle();
      set_uop(0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0);
      set_wb(0, 4'd0);
   endtask

   // Compare one cycle against the model, then advance both by one edge
   task automatic step();
      logic [3:0]  s [4];
      logic [3:0]  fwd;
      logic [15:0] pend;
      bit stall, ok, fire;
      int c, d, nk [16];
      #1;
      s[0] = uop_src1_i;
      s[1] = uop_src2_i;
      s[2] = uop_src3_i;
      s[3] = uop_src4_i;
      c = int'(uop_class_i);
      d = int'(uop_dest_i);
      stall = 0;
      fwd = '0;
      for (int i = 0; i < 4; i++) begin
         if (uop_src_en_i[i] && s[i] != 4'd15) begin
            if (kind[s[i]] == K_DO) fwd[i] = 1'b1;
            else if (kind[s[i]] != K_NONE) stall = 1;
         end
      end
      if (uop_dest_en_i && d != 15 && (kind[d] == K_M || kind[d] == K_LD))
         stall = 1;
      if (uop_cpsr_rd_i && cpsr_p) stall = 1;
      case (c)
         1: ok = (m_left <= 0);
         2: ok = (ld_n < LD_MAX) || (ld_n == LD_MAX && wb_valid_i);
         default: ok = 1;
      endcase
      fire = uop_valid_i && !stall && ok;
      for (int r = 0; r < 16; r++) pend[r] = (kind[r] != K_NONE);

      chk("ready", uop_ready_o, !stall && ok);
      chk("issue_do", issue_do_o, fire && c == 0);
      chk("issue_m", issue_m_o, fire && c == 1);
      chk("issue_mem", issue_mem_o, fire && c >= 2);
      chk("fwd_mask", fwd_mask_o, fire ? fwd : 4'd0);
      chk("pending", pending_o, pend);
      chk("m_busy", m_busy_o, m_left >= 0);
      chk("ld_count", ld_count_o, ld_n);
      chk("err", err_o, err_m);

      nk = kind;
      for (int r = 0; r < 16; r++) if (kind[r] == K_DO) nk[r] = K_NONE;
      if (m_left > 0) begin
         m_left--;
      end else if (m_left == 0) begin
         if (m_reg >= 0 && kind[m_reg] == K_M) nk[m_reg] = K_NONE;
         m_left = -1;
      end
      if (fire && c == 1) begin
         m_left = M_LATENCY - 1;
         m_reg  = (uop_dest_en_i && d != 15) ? d : -1;
      end
      if (wb_valid_i) begin
         if (ld_n > 0) begin
            if (kind[wb_dest_i] == K_LD) nk[wb_dest_i] = K_NONE;
            ld_n--;
            if (ldq.size() > 0) void'(ldq.pop_front());
         end else begin
            err_m = 1'b1;
         end
      end
      if (fire && c == 2) begin
         ld_n++;
         ldq.push_back(uop_dest_en_i ? d : 15);
      end
      if (fire && c != 3 && uop_dest_en_i && d != 15)
         nk[d] = (c == 0) ? K_DO : ((c == 1) ? K_M : K_LD);
      cpsr_p = fire && c == 0 && uop_cpsr_wr_i;
      kind = nk;
      last_fire = fire;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hold(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         step();
         if (last_fire) break;
      end
      chk(tag, last_fire, 1'b1);
   endtask

   function automatic logic [3:0] pick();
      if ($urandom_range(0, 7) == 0) return 4'd15;
      return 4'($urandom_range(0, 7));
   endfunction

   task automatic rand_in();
      uop_valid_i   = ($urandom_range(0, 9) < 8);
      uop_class_i   = 2'($urandom_range(0, 3));
      uop_src_en_i  = 4'($urandom);
      uop_src1_i    = pick();
      uop_src2_i    = pick();
      uop_src3_i    = pick();
      uop_src4_i    = pick();
      uop_dest_en_i = ($urandom_range(0, 9) < 7);
      uop_dest_i    = pick();
      uop_cpsr_rd_i = ($urandom_range(0, 3) == 0);
      uop_cpsr_wr_i = ($urandom_range(0, 3) == 0);
      if (ld_n > 0) wb_valid_i = ($urandom_range(0, 9) < 3);
      else wb_valid_i = ($urandom_range(0, 199) == 0);
      wb_dest_i = (ldq.size() > 0) ? 4'(ldq[0]) : pick();
   endtask

   task automatic check_reset(input string tag);
      #1;
      chk({tag, "_ready"}, uop_ready_o, 1'b0);
      chk({tag, "_issue"}, {issue_do_o, issue_m_o, issue_mem_o}, 3'b000);
      chk({tag, "_pending"}, pending_o, 16'h0000);
      chk({tag, "_m_busy"}, m_busy_o, 1'b0);
      chk({tag, "_ld_count"}, ld_count_o, 2'd0);
      chk({tag, "_err"}, err_o, 1'b0);
      chk({tag, "_fwd"}, fwd_mask_o, 4'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      set_uop(1, 0, 4'b0001, 4'd1, 1, 4'd2, 0, 0);
      model_reset();
      @(negedge clk);
      check_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      // DO then dependent DO: forwarded, back to back
      set_uop(1, 0, 4'b0001, 4'd1, 1, 4'd2, 0, 0);
      step();
      chk("do1_issue", last_fire, 1'b1);
      set_uop(1, 0, 4'b0001, 4'd2, 0, 4'd0, 0, 0);
      step();
      chk("do2_issue", last_fire, 1'b1);
      idle();
      step();

      // multiply r3 then dependent DO
      set_uop(1, 1, 4'b0000, 4'd0, 1, 4'd3, 0, 0);
      step();
      set_uop(1, 0, 4'b0001, 4'd3, 1, 4'd9, 0, 0);
      hold("mul_dep_do", 10);
      idle();
      step();

      // back-to-back multiplies
      set_uop(1, 1, 4'b0000, 4'd0, 1, 4'd4, 0, 0);
      hold("mul_r4", 10);
      set_uop(1, 1, 4'b0000, 4'd0, 1, 4'd5, 0, 0);
      hold("mul_r5", 10);
      chk("mul_b2b_busy", m_busy_o, 1'b1);
      idle();
      repeat (6) step();

      // load limit with writeback in the stall cycle
      set_uop(1, 2, 4'b0000, 4'd0, 1, 4'd6, 0, 0);
      step();
      set_uop(1, 2, 4'b0000, 4'd0, 1, 4'd7, 0, 0);
      step();
      set_uop(1, 2, 4'b0000, 4'd0, 1, 4'd8, 0, 0);
      step();
      chk("ld3_stalled", last_fire, 1'b0);
      set_wb(1, 4'd6);
      step();
      chk("ld3_with_wb", last_fire, 1'b1);
      idle();
      step();
      set_wb(1, 4'd7);
      step();
      set_wb(1, 4'd8);
      step();
      idle();
      step();

      // CMP then conditional DO
      set_uop(1, 0, 4'b0001, 4'd1, 0, 4'd0, 0, 1);
      step();
      set_uop(1, 0, 4'b0000, 4'd0, 1, 4'd9, 1, 0);
      step();
      chk("cond_stall", last_fire, 1'b0);
      step();
      chk("cond_issue", last_fire, 1'b1);

      // writeback with nothing outstanding
      idle();
      set_wb(1, 4'd5);
      step();
      idle();
      repeat (3) step();

      // reset while the multiplier is mid-flight
      set_uop(1, 1, 4'b0000, 4'd0, 1, 4'd10, 0, 0);
      step();
      idle();
      step();
      chk("mul_cnt2_busy", m_busy_o, 1'b1);
      rst = 1'b1;
      check_reset("midreset");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      set_uop(1, 1, 4'b0000, 4'd0, 1, 4'd11, 0, 0);
      step();
      chk("mul_after_rst", last_fire, 1'b1);
      idle();
      repeat (6) step();

      for (int i = 0; i < 3000; i++) begin
         rand_in();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
